// File: rtl/ysyx_22051013_idu_issue_pkg.sv
// Shared definitions for the decode-issue stage.
// Holds default widths, the forwarding-entry layout, the ID/EX slot control
// bundle and the reset values used by the slot and the stall counter.
package ysyx_22051013_idu_issue_pkg;

  localparam int PKG_XLEN       = 64;
  localparam int PKG_NREG       = 32;
  localparam int PKG_RA         = $clog2(PKG_NREG);
  localparam int PKG_FWD_STAGES = 3;
  localparam int PKG_MAX_PEND   = 3;

  typedef struct packed {
    logic                valid;
    logic [PKG_RA-1:0]   addr;
    logic [PKG_XLEN-1:0] data;
  } fwd_entry_t;

  typedef struct packed {
    logic valid;
    logic rd_ena;
    logic is_load;
  } slot_ctrl_t;

  localparam slot_ctrl_t  SLOT_CTRL_RST = '0;
  localparam logic [31:0] STALL_CNT_RST = '0;

endpackage

// File: rtl/ysyx_22051013_idu_sbtable.sv
// Pending-load scoreboard: one small counter per architectural register.
// Ports:
//   clk, rst                 clock, async active-high reset
//   inc, inc_addr            count one more outstanding load on inc_addr
//   dec, dec_addr            one load on dec_addr has written back
//   ra_a/cnt_a, ra_b/cnt_b   source read ports
//   ra_c/cnt_c               destination read port (load admission)
//   underflow                sticky: a decrement hit a zero counter
module ysyx_22051013_idu_sbtable
  import ysyx_22051013_idu_issue_pkg::*;
#(
  parameter int NREG     = PKG_NREG,
  parameter int MAX_PEND = PKG_MAX_PEND,
  localparam int RA      = $clog2(NREG),
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [RA-1:0] inc_addr,
  input  logic          dec,
  input  logic [RA-1:0] dec_addr,
  input  logic [RA-1:0] ra_a,
  output logic [CW-1:0] cnt_a,
  input  logic [RA-1:0] ra_b,
  output logic [CW-1:0] cnt_b,
  input  logic [RA-1:0] ra_c,
  output logic [CW-1:0] cnt_c,
  output logic          underflow
);

  logic [CW-1:0] pend [NREG];
  logic          cancel;

  // A dispatch and a write-back on the same register net to zero.
  assign cancel = inc && dec && (inc_addr == dec_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
      underflow <= 1'b0;
    end else begin
      if (inc && !cancel) pend[inc_addr] <= pend[inc_addr] + CW'(1);
      if (dec && !cancel) begin
        if (pend[dec_addr] != '0) pend[dec_addr] <= pend[dec_addr] - CW'(1);
        else                      underflow <= 1'b1;
      end
    end
  end

  assign cnt_a = pend[ra_a];
  assign cnt_b = pend[ra_b];
  assign cnt_c = pend[ra_c];

endmodule

// File: rtl/ysyx_22051013_idu_issue.sv
// Decode-issue stage: operand forwarding, pending-load hazard detection and
// a registered ID/EX slot with valid/ready handshake and flush.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_* / in_ready                  decoded instruction and acceptance
//   rs1_addr, rs2_addr / rs*_data    regfile read (address 0 if source unused)
//   fwd_valid/fwd_addr/fwd_data      packed forwarding entries, index 0 youngest
//   ld_done_valid, ld_done_addr      load write-back notification
//   flush                            kill the slot and the current input
//   out_* / out_ready                ID/EX slot towards the EXU
//   stall_cnt                        saturating hazard-stall cycle count
//   sb_err                           sticky scoreboard underflow flag
module ysyx_22051013_idu_issue
  import ysyx_22051013_idu_issue_pkg::*;
#(
  parameter int XLEN       = PKG_XLEN,
  parameter int NREG       = PKG_NREG,
  parameter int FWD_STAGES = PKG_FWD_STAGES,
  parameter int MAX_PEND   = PKG_MAX_PEND,
  localparam int RA        = $clog2(NREG),
  localparam int CW        = $clog2(MAX_PEND + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_rs1_ena,
  input  logic                     in_rs2_ena,
  input  logic [RA-1:0]            in_rs1_addr,
  input  logic [RA-1:0]            in_rs2_addr,
  input  logic [RA-1:0]            in_rd_addr,
  input  logic                     in_rd_ena,
  input  logic                     in_is_load,
  output logic [RA-1:0]            rs1_addr,
  output logic [RA-1:0]            rs2_addr,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  input  logic [FWD_STAGES-1:0]    fwd_valid,
  input  logic [FWD_STAGES*RA-1:0] fwd_addr,
  input  logic [FWD_STAGES*XLEN-1:0] fwd_data,
  input  logic                     ld_done_valid,
  input  logic [RA-1:0]            ld_done_addr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_op1,
  output logic [XLEN-1:0]          out_op2,
  output logic [RA-1:0]            out_rd_addr,
  output logic                     out_rd_ena,
  output logic                     out_is_load,
  output logic [31:0]              stall_cnt,
  output logic                     sb_err
);

  slot_ctrl_t             ctrl_q;
  logic [CW-1:0]          cnt1, cnt2, cnt_rd;
  logic                   rs1_use, rs2_use, slot_ld;
  logic                   haz1, haz2, blocked, accept, dispatch;
  logic [CW:0]            occ;
  logic [FWD_STAGES-1:0]  hit1, hit2;
  logic [XLEN-1:0]        pick1, pick2, op1, op2;

  assign out_valid   = ctrl_q.valid;
  assign out_rd_ena  = ctrl_q.rd_ena;
  assign out_is_load = ctrl_q.is_load;

  assign rs1_use  = in_rs1_ena && (in_rs1_addr != '0);
  assign rs2_use  = in_rs2_ena && (in_rs2_addr != '0);
  assign rs1_addr = in_rs1_ena ? in_rs1_addr : '0;
  assign rs2_addr = in_rs2_ena ? in_rs2_addr : '0;
  assign slot_ld  = ctrl_q.valid && ctrl_q.is_load;

  assign haz1 = rs1_use && ((cnt1 != '0) || (slot_ld && (out_rd_addr == in_rs1_addr)));
  assign haz2 = rs2_use && ((cnt2 != '0) || (slot_ld && (out_rd_addr == in_rs2_addr)));

  // The load still waiting in the slot is counted as outstanding too, so a
  // load accepted while another is dispatching can never push a counter
  // beyond MAX_PEND.
  assign occ     = {1'b0, cnt_rd} + {{CW{1'b0}}, (slot_ld && (out_rd_addr == in_rd_addr))};
  assign blocked = in_is_load && (in_rd_addr != '0) && (occ >= (CW+1)'(MAX_PEND));

  assign in_ready = !haz1 && !haz2 && !blocked && (!ctrl_q.valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign dispatch = ctrl_q.valid && out_ready && ctrl_q.is_load && (out_rd_addr != '0);

  for (genvar i = 0; i < FWD_STAGES; i++) begin : g_fwd
    assign hit1[i] = fwd_valid[i] && (fwd_addr[i*RA +: RA] == in_rs1_addr);
    assign hit2[i] = fwd_valid[i] && (fwd_addr[i*RA +: RA] == in_rs2_addr);
  end

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    pick1 = rs1_data;
    pick2 = rs2_data;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (hit1[i]) pick1 = fwd_data[i*XLEN +: XLEN];
      if (hit2[i]) pick2 = fwd_data[i*XLEN +: XLEN];
    end
  end

  assign op1 = rs1_use ? pick1 : '0;
  assign op2 = rs2_use ? pick2 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= SLOT_CTRL_RST;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rd_addr <= '0;
    end else if (flush) begin
      ctrl_q.valid <= 1'b0;
    end else if (accept) begin
      ctrl_q      <= '{valid: 1'b1, rd_ena: in_rd_ena, is_load: in_is_load};
      out_op1     <= op1;
      out_op2     <= op2;
      out_rd_addr <= in_rd_addr;
    end else if (out_ready) begin
      ctrl_q.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= STALL_CNT_RST;
    end else if (in_valid && !in_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  ysyx_22051013_idu_sbtable #(
    .NREG     (NREG),
    .MAX_PEND (MAX_PEND)
  ) u_sbtable (
    .clk       (clk),
    .rst       (rst),
    .inc       (dispatch),
    .inc_addr  (out_rd_addr),
    .dec       (ld_done_valid),
    .dec_addr  (ld_done_addr),
    .ra_a      (in_rs1_addr),
    .cnt_a     (cnt1),
    .ra_b      (in_rs2_addr),
    .cnt_b     (cnt2),
    .ra_c      (in_rd_addr),
    .cnt_c     (cnt_rd),
    .underflow (sb_err)
  );

endmodule
